// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive blocks.
//   - uart_state_e         : frame FSM states
//   - PAR_EVEN / PAR_ODD   : encoding of the par_typ input
//   - UART_DATA_WIDTH      : default data bits per frame
//   - UART_PRESCALE_WIDTH  : default width of the prescale input
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH     = 8;
  localparam int UART_PRESCALE_WIDTH = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/parity_calc.sv
// ---------------------------------------------------------------------------
// parity_calc
// Combinational parity of a DATA_WIDTH word. Shared with the receive-side
// parity checker so both ends agree on the convention.
// Ports:
//   data     in  [DATA_WIDTH-1:0]  word to protect
//   par_typ  in  1                 PAR_EVEN / PAR_ODD
//   par_bit  out 1                 bit that makes the total parity even/odd
// ---------------------------------------------------------------------------
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity: XOR of the data; odd parity: its inverse.
  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. A word accepted through data_valid is sent on
// tx_out as: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// stop bit(s). Every bit is held for P clocks, P being the prescale value
// latched with the word (0 is treated as 1).
//
// Build option:
//   UART_TX_TWO_STOP_EN  defined   -> two stop bits (STOP lasts 2*P clocks)
//                        undefined -> one stop bit
//
// Ports:
//   clk         in  1                 clock, rising edge
//   rst         in  1                 asynchronous reset, active low
//   p_data      in  [DATA_WIDTH-1:0]  word to transmit
//   data_valid  in  1                 request; only looked at in IDLE or in
//                                     the last stop cycle
//   par_en      in  1                 1 = append parity bit
//   par_typ     in  1                 0 = even, 1 = odd parity
//   prescale    in  [PRESCALE_WIDTH-1:0] clocks per bit
//   tx_out      out 1                 registered serial line, idles high
//   busy        out 1                 registered, high while a frame is sent
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

  uart_state_e               state, state_nxt;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]          bit_idx, bit_idx_nxt;

  // Word and frame configuration held for the whole frame.
  logic [DATA_WIDTH-1:0]     data_r, data_nxt;
  logic                      par_en_r, par_en_nxt;
  logic                      par_typ_r, par_typ_nxt;
  logic [PRESCALE_WIDTH-1:0] presc_r, presc_nxt;

`ifdef UART_TX_TWO_STOP_EN
  // Set once the first of the two stop bits has been sent.
  logic                      stop2, stop2_nxt;
`endif

  logic last;
  logic load;
  logic par_bit;
  logic tx_nxt;

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (data_r),
    .par_typ (par_typ_r),
    .par_bit (par_bit)
  );

  // Final clock of the current bit period.
  assign last = (cnt == presc_r - ONE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    data_nxt    = data_r;
    par_en_nxt  = par_en_r;
    par_typ_nxt = par_typ_r;
    presc_nxt   = presc_r;
    load        = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop2_nxt   = stop2;
`endif

    case (state)
      IDLE: begin
        if (data_valid) load = 1'b1;
      end

      START: begin
        if (last) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      DATA: begin
        if (last) begin
          cnt_nxt = '0;
          if (bit_idx == LAST_IDX) begin
            state_nxt = par_en_r ? PARITY : STOP;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      PARITY: begin
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end

      STOP: begin
        if (last) cnt_nxt = '0;
        else      cnt_nxt = cnt + ONE;
`ifdef UART_TX_TWO_STOP_EN
        if (last && !stop2) begin
          stop2_nxt = 1'b1;
        end else
`endif
        if (last) begin
`ifdef UART_TX_TWO_STOP_EN
          stop2_nxt = 1'b0;
`endif
          // Back-to-back frames: a request in the final stop clock starts
          // the next start bit with no idle gap.
          if (data_valid) load = 1'b1;
          else            state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (load) begin
      state_nxt   = START;
      cnt_nxt     = '0;
      data_nxt    = p_data;
      par_en_nxt  = par_en;
      par_typ_nxt = par_typ;
      presc_nxt   = (prescale == '0) ? ONE : prescale;
    end
  end

  // Line level for the next cycle, so tx_out is a plain flop output.
  // Entering DATA or PARITY never coincides with a load, so data_r is
  // already the word being sent.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_r[bit_idx_nxt];
      PARITY:  tx_nxt = par_bit;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      tx_out  <= tx_nxt;
      busy    <= (state_nxt != IDLE);
`ifdef UART_TX_TWO_STOP_EN
      stop2   <= stop2_nxt;
`endif
    end
  end

  // Held word and configuration; only meaningful after a load, so no reset.
  always_ff @(posedge clk) begin
    data_r    <= data_nxt;
    par_en_r  <= par_en_nxt;
    par_typ_r <= par_typ_nxt;
    presc_r   <= presc_nxt;
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd0;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Walks one frame cycle by cycle. pbit is the hand-computed parity bit.
  // inj_at >= 0 raises data_valid with inj_d (and disturbs the config
  // inputs) during that cycle; if it is the last cycle the idle check is
  // skipped because the next frame follows immediately.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pbit, input int p, input int inj_at,
                             input logic [7:0] inj_d);
    logic bits [0:11];
    int   n;
    int   total;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (pe) begin
      bits[n] = pbit;
      n++;
    end
    for (int s = 0; s < NSTOP; s++) begin
      bits[n] = 1'b1;
      n++;
    end
    total = n * p;
    for (int c = 0; c < total; c++) begin
      chk($sformatf("%s c%0d tx", tag, c), tx_out, bits[c/p]);
      chk($sformatf("%s c%0d busy", tag, c), busy, 1'b1);
      if (c == inj_at) begin
        p_data     = inj_d;
        data_valid = 1'b1;
        if (c != total - 1) begin
          par_en   = ~par_en;
          prescale = 6'd5;
        end
      end
      tick();
      data_valid = 1'b0;
    end
    if (inj_at != total - 1) begin
      chk($sformatf("%s idle tx", tag), tx_out, 1'b1);
      chk($sformatf("%s idle busy", tag), busy, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset tx", tx_out, 1'b1);
    chk("reset busy", busy, 1'b0);
    rst = 1'b1;
    tick();
    chk("post reset tx", tx_out, 1'b1);
    chk("post reset busy", busy, 1'b0);

    // 1: basic 8N1 frame, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 6'd1);
    check_frame("t1", 8'hA5, 1'b0, 1'b0, 1, -1, 8'h00);

    // 2: parity variants
    send(8'hA5, 1'b1, 1'b0, 6'd1);
    check_frame("t2 A5 even", 8'hA5, 1'b1, 1'b0, 1, -1, 8'h00);
    send(8'hA5, 1'b1, 1'b1, 6'd1);
    check_frame("t2 A5 odd", 8'hA5, 1'b1, 1'b1, 1, -1, 8'h00);
    send(8'h07, 1'b1, 1'b0, 6'd1);
    check_frame("t2 07 even", 8'h07, 1'b1, 1'b1, 1, -1, 8'h00);

    // 3: prescale 8, and prescale 0 behaving as 1
    send(8'h01, 1'b0, 1'b0, 6'd8);
    check_frame("t3 p8", 8'h01, 1'b0, 1'b0, 8, -1, 8'h00);
    send(8'h01, 1'b0, 1'b0, 6'd0);
    check_frame("t3 p0", 8'h01, 1'b0, 1'b0, 1, -1, 8'h00);

    // 4: back-to-back, next request in the last stop cycle
    send(8'hA5, 1'b0, 1'b0, 6'd1);
    check_frame("t4 first", 8'hA5, 1'b0, 1'b0, 1, 9 + NSTOP - 1, 8'h3C);
    check_frame("t4 second", 8'h3C, 1'b0, 1'b0, 1, -1, 8'h00);

    // 5: request during DATA is ignored, nothing queued
    send(8'h00, 1'b0, 1'b0, 6'd1);
    check_frame("t5", 8'h00, 1'b0, 1'b0, 1, 4, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5 after%0d tx", k), tx_out, 1'b1);
      chk($sformatf("t5 after%0d busy", k), busy, 1'b0);
    end

    // 6: asynchronous reset in the middle of data bit 1 (a zero of 0xA5)
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    for (int k = 0; k < 19; k++) tick();
    chk("t6 pre tx", tx_out, 1'b0);
    chk("t6 pre busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6 async tx", tx_out, 1'b1);
    chk("t6 async busy", busy, 1'b0);
    #3;
    rst = 1'b1;
    tick();
    chk("t6 released tx", tx_out, 1'b1);
    chk("t6 released busy", busy, 1'b0);
    send(8'h3C, 1'b1, 1'b1, 6'd2);
    check_frame("t6 clean", 8'h3C, 1'b1, 1'b1, 2, -1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
